// File: rtl/wt_sched_pkg.sv
// rtl/wt_sched_pkg.sv - shared widths, FSM states and saturating-add helpers for the sum scheduler
package wt_sched_pkg;

  localparam int OPW   = 4;
  localparam int NOPS  = 4;
  localparam int TSUMW = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // a + b clamped to the largest w-bit value
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [32:0] sum;
    logic [32:0] lim;
    lim = (33'd1 << w) - 33'd1;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > lim) begin
      sat_add = lim[31:0];
    end else begin
      sat_add = sum[31:0];
    end
  endfunction

  // 1 when a + b does not fit in w bits
  function automatic logic add_ovf(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [32:0] sum;
    logic [32:0] lim;
    lim = (33'd1 << w) - 33'd1;
    sum = {1'b0, a} + {1'b0, b};
    add_ovf = (sum > lim);
  endfunction

endpackage

// File: rtl/wt_4_3p03p03p03p0.sv
// rtl/wt_4_3p03p03p03p0.sv - combinational 4-operand x 4-bit compressor tree producing a 6-bit sum
module wt_4_3p03p03p03p0
  import wt_sched_pkg::*;
(
  input  logic [NOPS*OPW-1:0] i_ops,
  output logic [TSUMW-1:0]    o_sum
);

  logic [OPW-1:0] w_a;
  logic [OPW-1:0] w_b;
  logic [OPW-1:0] w_c;
  logic [OPW-1:0] w_d;
  logic [OPW-1:0] w_s;
  logic [OPW-1:0] w_cy;

  assign w_a = i_ops[0*OPW +: OPW];
  assign w_b = i_ops[1*OPW +: OPW];
  assign w_c = i_ops[2*OPW +: OPW];
  assign w_d = i_ops[3*OPW +: OPW];

  // 3:2 carry-save layer folds three operands into sum + carry vectors
  assign w_s  = w_a ^ w_b ^ w_c;
  assign w_cy = (w_a & w_b) | (w_a & w_c) | (w_b & w_c);

  // final carry-propagate add with the fourth operand
  assign o_sum = TSUMW'(w_s) + (TSUMW'(w_cy) << 1) + TSUMW'(w_d);

endmodule

// File: rtl/wt_rr_arbiter.sv
// rtl/wt_rr_arbiter.sv - round-robin pick of the first request at or after a pointer
module wt_rr_arbiter
  import wt_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  // search from the pointer to the top first, then wrap round to index 0
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (!o_any && i_req[j] && (j >= int'(i_ptr))) begin
        o_any      = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = IDW'(j);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!o_any && i_req[j]) begin
        o_any      = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/wt_sum_scheduler.sv
// rtl/wt_sum_scheduler.sv - round-robin burst scheduler sharing one compressor tree, with saturating accumulation
module wt_sum_scheduler
  import wt_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int ACCW = 8,
  parameter int CNTW = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NREQ-1:0]          i_req_valid,
  input  logic [NREQ-1:0]          i_req_last,
  input  logic [NREQ*NOPS*OPW-1:0] i_req_ops,
  output logic [NREQ-1:0]          o_req_ready,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [IDW-1:0]           o_rsp_id,
  output logic [ACCW-1:0]          o_rsp_sum,
  output logic [CNTW-1:0]          o_rsp_beats,
  output logic                     o_rsp_ovf
);

  localparam int BEATW = NOPS * OPW;

  state_t            r_state;
  state_t            w_state_next;
  logic [IDW-1:0]    r_grant;
  logic [NREQ-1:0]   r_grant_oh;
  logic [IDW-1:0]    r_ptr;
  logic [ACCW-1:0]   r_acc;
  logic [CNTW-1:0]   r_cnt;
  logic              r_ovf;

  logic [NREQ-1:0]   w_arb_grant;
  logic [IDW-1:0]    w_arb_idx;
  logic              w_arb_any;
  logic [BEATW-1:0]  w_sel_ops;
  logic [TSUMW-1:0]  w_tree_sum;
  logic              w_beat_acc;
  logic              w_beat_last;

  wt_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .i_req   (i_req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_any   (w_arb_any)
  );

  // route the granted requester's operands into the shared tree
  always_comb begin
    w_sel_ops = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_grant == IDW'(i)) begin
        w_sel_ops = i_req_ops[i*BEATW +: BEATW];
      end
    end
  end

  wt_4_3p03p03p03p0 u_tree (
    .i_ops (w_sel_ops),
    .o_sum (w_tree_sum)
  );

  assign w_beat_acc  = (r_state == BUSY) && |(i_req_valid & r_grant_oh);
  assign w_beat_last = |(i_req_last & r_grant_oh);

  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // next-state and handshake outputs; grant stays locked in BUSY until the last beat
  always_comb begin
    w_state_next = r_state;
    o_req_ready  = '0;
    o_rsp_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_arb_any) begin
          w_state_next = BUSY;
        end
      end
      BUSY: begin
        o_req_ready = r_grant_oh;
        if (w_beat_acc && w_beat_last) begin
          w_state_next = RESP;
        end
      end
      RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // grant latch, saturating accumulate per beat, pointer advance after the response handshake
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_grant    <= '0;
      r_grant_oh <= '0;
      r_ptr      <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if ((r_state == IDLE) && w_arb_any) begin
        r_grant    <= w_arb_idx;
        r_grant_oh <= w_arb_grant;
        r_acc      <= '0;
        r_cnt      <= '0;
        r_ovf      <= 1'b0;
      end
      if (w_beat_acc) begin
        r_acc <= ACCW'(sat_add(32'(r_acc), 32'(w_tree_sum), ACCW));
        r_cnt <= CNTW'(sat_add(32'(r_cnt), 32'd1, CNTW));
        r_ovf <= r_ovf
               | add_ovf(32'(r_acc), 32'(w_tree_sum), ACCW)
               | add_ovf(32'(r_cnt), 32'd1, CNTW);
      end
      if ((r_state == RESP) && i_rsp_ready) begin
        r_ptr <= (r_grant == IDW'(NREQ - 1)) ? '0 : r_grant + IDW'(1);
      end
    end
  end

  assign o_rsp_id    = r_grant;
  assign o_rsp_sum   = r_acc;
  assign o_rsp_beats = r_cnt;
  assign o_rsp_ovf   = r_ovf;

endmodule

// File: tb/tb_wt_sum_scheduler.sv
// tb/tb_wt_sum_scheduler.sv - self-checking bench for wt_sum_scheduler
module tb_wt_sum_scheduler;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int ACCW = 8;
  localparam int CNTW = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_last = '0;
  logic [NREQ*16-1:0]   req_ops = '0;
  logic [NREQ-1:0]      req_ready;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b0;
  logic [IDW-1:0]       rsp_id;
  logic [ACCW-1:0]      rsp_sum;
  logic [CNTW-1:0]      rsp_beats;
  logic                 rsp_ovf;

  always #5 clk = ~clk;

  wt_sum_scheduler #(
    .NREQ (NREQ),
    .IDW  (IDW),
    .ACCW (ACCW),
    .CNTW (CNTW)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .i_req_last  (req_last),
    .i_req_ops   (req_ops),
    .o_req_ready (req_ready),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_id    (rsp_id),
    .o_rsp_sum   (rsp_sum),
    .o_rsp_beats (rsp_beats),
    .o_rsp_ovf   (rsp_ovf)
  );

  int n_cmp = 0;
  int n_fail = 0;

  logic [16:0] beat_q[NREQ][$];
  int          exp_q[NREQ][$];
  int          rsp_ids[$];
  int          last_id, last_sum, last_beats, last_ovf, eng_cycles;

  function automatic int pack_exp(input int sum, input int beats, input int ovf);
    return sum | (beats << 8) | (ovf << 12);
  endfunction

  // response of a burst from its plain total and length
  function automatic int model_rsp(input int total, input int len);
    int lim_s;
    int lim_b;
    lim_s = (1 << ACCW) - 1;
    lim_b = (1 << CNTW) - 1;
    return pack_exp(total > lim_s ? lim_s : total, len > lim_b ? lim_b : len,
                    (total > lim_s || len > lim_b) ? 1 : 0);
  endfunction

  task automatic push_burst(input int r, input int len, input logic [15:0] fixed_ops, input bit rnd);
    int tot;
    logic [15:0] ops;
    tot = 0;
    for (int b = 0; b < len; b++) begin
      ops = rnd ? 16'($urandom) : fixed_ops;
      tot += int'(ops[3:0]) + int'(ops[7:4]) + int'(ops[11:8]) + int'(ops[15:12]);
      beat_q[r].push_back({(b == len - 1) ? 1'b1 : 1'b0, ops});
    end
    exp_q[r].push_back(model_rsp(tot, len));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = '0;
    req_last = '0;
    req_ops = '0;
    rsp_ready = 1'b0;
    for (int r = 0; r < NREQ; r++) begin
      beat_q[r].delete();
      exp_q[r].delete();
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_engine(input int budget, input int gap_pct, input int rdy_pct);
    int cyc;
    int got;
    int want;
    bit busy;
    logic [16:0] bt;
    cyc = 0;
    rsp_ids.delete();
    while (1) begin
      busy = 1'b0;
      for (int r = 0; r < NREQ; r++) begin
        if (beat_q[r].size() != 0 || exp_q[r].size() != 0) busy = 1'b1;
      end
      if (!busy) break;
      if (cyc >= budget) begin
        n_cmp++;
        n_fail++;
        $display("FAIL engine_timeout: used %0d cycles, budget %0d", cyc, budget);
        break;
      end
      next_cycle();
      req_valid = '0;
      req_last = '0;
      for (int r = 0; r < NREQ; r++) begin
        if (beat_q[r].size() != 0 && $urandom_range(0, 99) >= gap_pct) begin
          bt = beat_q[r][0];
          req_valid[r] = 1'b1;
          req_last[r] = bt[16];
          req_ops[r*16 +: 16] = bt[15:0];
        end
      end
      rsp_ready = ($urandom_range(0, 99) < rdy_pct);
      @(negedge clk);
      n_cmp++;
      if (!$onehot0(req_ready) || (rsp_valid && req_ready != '0)) begin
        n_fail++;
        $display("FAIL handshake_excl: req_ready=%b rsp_valid=%b, need onehot0 ready and not both", req_ready, rsp_valid);
      end
      for (int r = 0; r < NREQ; r++) begin
        if (req_valid[r] && req_ready[r]) void'(beat_q[r].pop_front());
      end
      if (rsp_valid && rsp_ready) begin
        n_cmp++;
        last_id = int'(rsp_id);
        last_sum = int'(rsp_sum);
        last_beats = int'(rsp_beats);
        last_ovf = int'(rsp_ovf);
        rsp_ids.push_back(last_id);
        got = pack_exp(last_sum, last_beats, last_ovf);
        if (exp_q[rsp_id].size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected: id=%0d got=%h, no burst outstanding", last_id, got);
        end else begin
          want = exp_q[rsp_id].pop_front();
          if (got !== want) begin
            n_fail++;
            $display("FAIL rsp_fields id=%0d: got sum=%0d beats=%0d ovf=%0d, want sum=%0d beats=%0d ovf=%0d",
                     last_id, last_sum, last_beats, last_ovf, want & 255, (want >> 8) & 15, (want >> 12) & 1);
          end
        end
      end
      cyc++;
    end
    eng_cycles = cyc;
    next_cycle();
    req_valid = '0;
    req_last = '0;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'hF;
    req_last = 4'hF;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_id, rsp_sum, rsp_beats, rsp_ovf} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", {req_ready, rsp_valid, rsp_id, rsp_sum, rsp_beats, rsp_ovf});
    end
    apply_reset();
    @(negedge clk);
    n_cmp++;
    if ({req_ready, rsp_valid} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got ready=%b rsp_valid=%b want 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_single_beat();
    apply_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    req_last = 4'b0001;
    req_ops = {48'h0, 16'h4321};
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_idle_ready: got %b want 0000", req_ready);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_accept_latency: got %b want 0001", req_ready);
    end
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_sum, rsp_beats, rsp_ovf, req_ready} !== {1'b1, 2'd0, 8'd10, 4'd1, 1'b0, 4'b0}) begin
      n_fail++;
      $display("FAIL single_rsp: got v=%b id=%0d sum=%0d beats=%0d ovf=%b rdy=%b want 1/0/10/1/0/0000",
               rsp_valid, rsp_id, rsp_sum, rsp_beats, rsp_ovf, req_ready);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_rsp_drop: got rsp_valid=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_burst();
    apply_reset();
    push_burst(2, 3, 16'hFFFF, 1'b0);
    run_engine(100, 0, 100);
    n_cmp++;
    if (rsp_ids.size() != 1 || last_id != 2 || last_sum != 180 || last_beats != 3 || last_ovf != 0) begin
      n_fail++;
      $display("FAIL burst3: got n=%0d id=%0d sum=%0d beats=%0d ovf=%0d want 1/2/180/3/0",
               rsp_ids.size(), last_id, last_sum, last_beats, last_ovf);
    end
    push_burst(2, 5, 16'hFFFF, 1'b0);
    run_engine(100, 0, 100);
    n_cmp++;
    if (rsp_ids.size() != 1 || last_id != 2 || last_sum != 255 || last_beats != 5 || last_ovf != 1) begin
      n_fail++;
      $display("FAIL burst5_sat: got n=%0d id=%0d sum=%0d beats=%0d ovf=%0d want 1/2/255/5/1",
               rsp_ids.size(), last_id, last_sum, last_beats, last_ovf);
    end
  endtask

  task automatic test_fairness();
    int want_ids[8];
    apply_reset();
    want_ids = '{0, 1, 2, 3, 0, 1, 2, 3};
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < NREQ; r++) push_burst(r, 1, 16'(16'h1111 * (r + 1)), 1'b0);
    end
    run_engine(200, 0, 100);
    n_cmp++;
    if (rsp_ids.size() != 8) begin
      n_fail++;
      $display("FAIL fair_count: got %0d responses want 8", rsp_ids.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (rsp_ids[i] != want_ids[i]) begin
          n_fail++;
          $display("FAIL fair_order[%0d]: got id %0d want %0d", i, rsp_ids[i], want_ids[i]);
        end
      end
    end
    n_cmp++;
    if (eng_cycles != 24) begin
      n_fail++;
      $display("FAIL fair_latency: got %0d cycles want 24", eng_cycles);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    req_last = 4'b0010;
    req_ops = {32'h0, 16'h2222, 16'h0};
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL bp_grant: got %b want 0010", req_ready);
    end
    next_cycle();
    req_valid = 4'b0001;
    req_last = 4'b0001;
    req_ops[15:0] = 16'h3333;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) next_cycle();
      if (c == 5) rsp_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid, rsp_id, rsp_sum, rsp_beats, rsp_ovf, req_ready} !== {1'b1, 2'd1, 8'd8, 4'd1, 1'b0, 4'b0}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got v=%b id=%0d sum=%0d beats=%0d ovf=%b rdy=%b want 1/1/8/1/0/0000",
                 c, rsp_valid, rsp_id, rsp_sum, rsp_beats, rsp_ovf, req_ready);
      end
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, req_ready} !== 5'b0) begin
      n_fail++;
      $display("FAIL bp_after_hs: got v=%b rdy=%b want 0/0000", rsp_valid, req_ready);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL bp_next_grant: got %b want 0001", req_ready);
    end
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_sum} !== {1'b1, 2'd0, 8'd12}) begin
      n_fail++;
      $display("FAIL bp_second_rsp: got v=%b id=%0d sum=%0d want 1/0/12", rsp_valid, rsp_id, rsp_sum);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_one_rsp: got rsp_valid=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_lock();
    logic [9:0] v1_m;
    logic [9:0] v0_m;
    logic [9:0] rv_m;
    int rdy_t[10];
    v1_m = 10'b0000100011;
    v0_m = 10'b0111111110;
    rv_m = 10'b1001000000;
    rdy_t = '{0, 2, 2, 2, 2, 2, 0, 0, 1, 0};
    apply_reset();
    rsp_ready = 1'b1;
    for (int t = 0; t < 10; t++) begin
      if (t > 0) next_cycle();
      req_valid = {2'b00, v1_m[t], v0_m[t]};
      req_last = {2'b00, (t >= 5) ? 1'b1 : 1'b0, 1'b1};
      req_ops = {32'h0, (t < 5) ? 16'h1111 : 16'h2222, 16'h3333};
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 4'(rdy_t[t]) || rsp_valid !== rv_m[t]) begin
        n_fail++;
        $display("FAIL lock_cycle[%0d]: got rdy=%b v=%b want rdy=%b v=%b", t, req_ready, rsp_valid, 4'(rdy_t[t]), rv_m[t]);
      end
      if (t == 6 || t == 9) begin
        n_cmp++;
        if ({rsp_id, rsp_sum, rsp_beats} !== ((t == 6) ? {2'd1, 8'd12, 4'd2} : {2'd0, 8'd12, 4'd1})) begin
          n_fail++;
          $display("FAIL lock_rsp[%0d]: got id=%0d sum=%0d beats=%0d", t, rsp_id, rsp_sum, rsp_beats);
        end
      end
    end
    next_cycle();
    req_valid = '0;
  endtask

  task automatic test_random();
    int nb;
    apply_reset();
    nb = 0;
    for (int r = 0; r < NREQ; r++) begin
      for (int k = 0; k < 5; k++) begin
        push_burst(r, $urandom_range(1, 5), 16'h0, 1'b1);
        nb++;
      end
    end
    push_burst(3, 17, 16'h0, 1'b1);
    push_burst(1, 6, 16'hFFFF, 1'b0);
    nb += 2;
    run_engine(4000, 25, 70);
    n_cmp++;
    if (rsp_ids.size() != nb) begin
      n_fail++;
      $display("FAIL random_count: got %0d responses want %0d", rsp_ids.size(), nb);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    req_last = 4'b0000;
    req_ops = {16'h0, 16'hFFFF, 32'h0};
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    next_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_id, rsp_sum, rsp_beats, rsp_ovf} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %h want 0", {req_ready, rsp_valid, rsp_id, rsp_sum, rsp_beats, rsp_ovf});
    end
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_valid = 4'b1001;
    req_last = 4'b1001;
    req_ops = {16'h0001, 32'h0, 16'h0002};
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid_idle: got %b want 0000", req_ready);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_mid_ptr: got %b want 0001", req_ready);
    end
    next_cycle();
    req_valid = 4'b1000;
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_sum, rsp_beats} !== {1'b1, 2'd0, 8'd2, 4'd1}) begin
      n_fail++;
      $display("FAIL reset_mid_rsp: got v=%b id=%0d sum=%0d beats=%0d want 1/0/2/1", rsp_valid, rsp_id, rsp_sum, rsp_beats);
    end
    next_cycle();
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_burst();
    test_fairness();
    test_backpressure();
    test_lock();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
